// File: rtl/bac_pkg.sv
// Shared Bulls-and-Cows constants: digit count, empty-nibble marker and
// the guess entry FSM encodings.
package bac_pkg;

    localparam int         NUM_DIGITS  = 4;
    localparam logic [3:0] EMPTY_DIGIT = 4'hF;

    localparam logic [1:0] COLLECT = 2'd0;
    localparam logic [1:0] PENDING = 2'd1;
    localparam logic [1:0] SHOWN   = 2'd2;

    function automatic logic [3:0] nibble_at(input logic [15:0] g, input int idx);
        return g[4*(NUM_DIGITS-1-idx) +: 4];
    endfunction

endpackage

// File: rtl/key_debouncer.sv
// Synchronises and debounces the ten digit keys, then emits a one-cycle
// press event with the digit index when exactly one key becomes pressed.
module key_debouncer #(
    parameter int DEBOUNCE_CYCLES = 500000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [9:0] key,
    output logic       press_evt,
    output logic [3:0] press_digit
);

    localparam int             CW     = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0] RELOAD = CW'(DEBOUNCE_CYCLES - 1);

    logic [9:0]    sync1;
    logic [9:0]    sync2;
    logic [9:0]    cand;
    logic [9:0]    stable_key;
    logic [CW-1:0] cnt;
    logic          settled;
    logic          armed;
    logic          one_hot;
    logic [3:0]    enc;

    always_comb begin
        one_hot = (cand != 10'd0) && ((cand & (cand - 10'd1)) == 10'd0);
        enc     = 4'd0;
        for (int i = 0; i < 10; i++) begin
            if (cand[i]) enc = 4'(i);
        end
    end

    // armed stays low until an all-released vector has been observed, so a
    // key held through reset never turns into a press.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1       <= '0;
            sync2       <= '0;
            cand        <= '0;
            stable_key  <= '0;
            cnt         <= '0;
            settled     <= 1'b0;
            armed       <= 1'b0;
            press_evt   <= 1'b0;
            press_digit <= 4'd0;
        end else begin
            sync1     <= key;
            sync2     <= sync1;
            settled   <= 1'b1;
            press_evt <= 1'b0;
            if (sync2 != cand) begin
                cand <= sync2;
                cnt  <= RELOAD;
            end else if (cnt != '0) begin
                cnt <= cnt - 1'b1;
            end else if (cand != stable_key) begin
                stable_key  <= cand;
                press_evt   <= armed && (stable_key == 10'd0) && one_hot;
                press_digit <= enc;
            end
            if (settled && sync1 == 10'd0 && sync2 == 10'd0 && cand == 10'd0 && cnt == '0)
                armed <= 1'b1;
        end
    end

endmodule

// File: rtl/guess_entry_buffer.sv
// Collects a four-digit guess from the debounced keys and offers it to the
// scoring logic over a valid/ready handshake.
import bac_pkg::*;

module guess_entry_buffer #(
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter bit ALLOW_DUP       = 1'b0
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [9:0]  key,
    input  logic        clear,
    input  logic        ready,
    output logic [15:0] guess,
    output logic [2:0]  digit_count,
    output logic        guess_valid,
    output logic        dup_reject,
    output logic [7:0]  attempts
);

    logic [1:0]  state;
    logic        press_evt;
    logic [3:0]  press_digit;
    logic        is_dup;
    logic [15:0] ins_guess;

    key_debouncer #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_key_debouncer (
        .clk        (clk),
        .rst_n      (rst_n),
        .key        (key),
        .press_evt  (press_evt),
        .press_digit(press_digit)
    );

    // Only nibbles below digit_count hold real digits.
    always_comb begin
        is_dup    = 1'b0;
        ins_guess = guess;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (3'(i) < digit_count && nibble_at(guess, i) == press_digit)
                is_dup = 1'b1;
            if (3'(i) == digit_count)
                ins_guess[4*(NUM_DIGITS-1-i) +: 4] = press_digit;
        end
    end

    assign guess_valid = (state == PENDING);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= COLLECT;
            guess       <= {NUM_DIGITS{EMPTY_DIGIT}};
            digit_count <= 3'd0;
            dup_reject  <= 1'b0;
            attempts    <= 8'd0;
        end else begin
            dup_reject <= 1'b0;
            if (clear) begin
                state       <= COLLECT;
                guess       <= {NUM_DIGITS{EMPTY_DIGIT}};
                digit_count <= 3'd0;
            end else begin
                case (state)
                    COLLECT: begin
                        if (press_evt) begin
                            if (!ALLOW_DUP && is_dup) begin
                                dup_reject <= 1'b1;
                            end else begin
                                guess       <= ins_guess;
                                digit_count <= digit_count + 3'd1;
                                if (digit_count == 3'(NUM_DIGITS - 1))
                                    state <= PENDING;
                            end
                        end
                    end
                    PENDING: begin
                        if (ready) begin
                            state <= SHOWN;
                            if (attempts != 8'hFF)
                                attempts <= attempts + 8'd1;
                        end
                    end
                    SHOWN: begin
                        if (press_evt) begin
                            guess       <= {press_digit, {(NUM_DIGITS-1){EMPTY_DIGIT}}};
                            digit_count <= 3'd1;
                            state       <= COLLECT;
                        end
                    end
                    default: state <= COLLECT;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_guess_entry_buffer.sv
// Bench for guess_entry_buffer: two instances (duplicates rejected / allowed)
// checked against a queue-based reference model through a change scoreboard.
module tb_guess_entry_buffer;

    localparam int D = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        clear = 1'b0;
    logic        ready = 1'b0;
    logic [9:0]  key = 10'd0;

    logic [15:0] g0, g1;
    logic [2:0]  c0, c1;
    logic        v0, v1, d0, d1;
    logic [7:0]  a0, a1;

    guess_entry_buffer #(.DEBOUNCE_CYCLES(D), .ALLOW_DUP(1'b0)) dut0 (
        .clk(clk), .rst_n(rst_n), .key(key), .clear(clear), .ready(ready),
        .guess(g0), .digit_count(c0), .guess_valid(v0), .dup_reject(d0), .attempts(a0));

    guess_entry_buffer #(.DEBOUNCE_CYCLES(D), .ALLOW_DUP(1'b1)) dut1 (
        .clk(clk), .rst_n(rst_n), .key(key), .clear(clear), .ready(ready),
        .guess(g1), .digit_count(c1), .guess_valid(v1), .dup_reject(d1), .attempts(a1));

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct packed {
        logic [15:0] g0; logic [2:0] c0; logic v0; logic d0; logic [7:0] a0;
        logic [15:0] g1; logic [2:0] c1; logic v1; logic d1; logic [7:0] a1;
    } obs_t;

    typedef struct {
        obs_t o;
        int   cyc;
    } exp_t;

    exp_t sb[$];
    obs_t last_push, prev_obs, mon_o;
    exp_t mon_e;
    bit   mon_en = 1'b0;
    int   checks = 0;
    int   errors = 0;

    // Reference model: 0 = entering digits, 1 = guess offered, 2 = guess shown
    int         m_st[2];
    int         m_cnt[2];
    int         m_att[2];
    bit         m_dup[2];
    logic [3:0] m_dig[2][4];

    function automatic obs_t model_obs();
        obs_t o;
        logic [15:0] g[2];
        for (int k = 0; k < 2; k++) begin
            g[k] = 16'hFFFF;
            for (int j = 0; j < m_cnt[k]; j++) g[k][15-4*j -: 4] = m_dig[k][j];
        end
        o.g0 = g[0]; o.c0 = 3'(m_cnt[0]); o.v0 = (m_st[0] == 1); o.d0 = m_dup[0]; o.a0 = 8'(m_att[0]);
        o.g1 = g[1]; o.c1 = 3'(m_cnt[1]); o.v1 = (m_st[1] == 1); o.d1 = m_dup[1]; o.a1 = 8'(m_att[1]);
        return o;
    endfunction

    function automatic void push_exp(input int c);
        obs_t o;
        exp_t e;
        o = model_obs();
        if (o !== last_push) begin
            e.o = o;
            e.cyc = c;
            sb.push_back(e);
            last_push = o;
        end
    endfunction

    function automatic void model_reset();
        for (int k = 0; k < 2; k++) begin
            m_st[k] = 0; m_cnt[k] = 0; m_att[k] = 0; m_dup[k] = 1'b0;
        end
    endfunction

    function automatic void model_press(input int d, input int c);
        bit seen;
        for (int k = 0; k < 2; k++) begin
            seen = 1'b0;
            for (int j = 0; j < m_cnt[k]; j++) if (m_dig[k][j] == 4'(d)) seen = 1'b1;
            if (m_st[k] == 0) begin
                if (k == 0 && seen) begin
                    m_dup[k] = 1'b1;
                end else begin
                    m_dig[k][m_cnt[k]] = 4'(d);
                    m_cnt[k]++;
                    if (m_cnt[k] == 4) m_st[k] = 1;
                end
            end else if (m_st[k] == 2) begin
                m_dig[k][0] = 4'(d);
                m_cnt[k] = 1;
                m_st[k] = 0;
            end
        end
        push_exp(c);
        if (m_dup[0] || m_dup[1]) begin
            m_dup[0] = 1'b0;
            m_dup[1] = 1'b0;
            push_exp(c + 1);
        end
    endfunction

    function automatic void model_clear(input int c);
        for (int k = 0; k < 2; k++) begin
            m_st[k] = 0;
            m_cnt[k] = 0;
        end
        push_exp(c);
    endfunction

    function automatic void model_ready(input int c);
        for (int k = 0; k < 2; k++) begin
            if (m_st[k] == 1) begin
                m_st[k] = 2;
                if (m_att[k] < 255) m_att[k]++;
            end
        end
        push_exp(c);
    endfunction

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", name, got, exp);
        end
    endtask

    task automatic press(input int d, input int hold, input int rel);
        @(posedge clk);
        #1;
        key = 10'd1 << d;
        model_press(d, cyc + D + 4);
        repeat (hold) @(posedge clk);
        #1;
        key = 10'd0;
        repeat (rel) @(posedge clk);
    endtask

    task automatic pulse_ready();
        @(posedge clk);
        #1;
        ready = 1'b1;
        model_ready(cyc + 1);
        @(posedge clk);
        #1;
        ready = 1'b0;
        repeat (3) @(posedge clk);
    endtask

    task automatic pulse_clear(input bit with_ready);
        @(posedge clk);
        #1;
        clear = 1'b1;
        ready = with_ready;
        model_clear(cyc + 1);
        @(posedge clk);
        #1;
        clear = 1'b0;
        ready = 1'b0;
        repeat (3) @(posedge clk);
    endtask

    always @(negedge clk) begin
        if (mon_en) begin
            mon_o.g0 = g0; mon_o.c0 = c0; mon_o.v0 = v0; mon_o.d0 = d0; mon_o.a0 = a0;
            mon_o.g1 = g1; mon_o.c1 = c1; mon_o.v1 = v1; mon_o.d1 = d1; mon_o.a1 = a1;
            if (mon_o !== prev_obs) begin
                prev_obs = mon_o;
                checks++;
                if (sb.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_change cyc=%0d got=%h", cyc, mon_o);
                end else begin
                    mon_e = sb.pop_front();
                    if (mon_o !== mon_e.o || (mon_e.cyc >= 0 && mon_e.cyc != cyc)) begin
                        errors++;
                        $display("FAIL sb_change cyc=%0d got=%h exp=%h exp_cyc=%0d",
                                 cyc, mon_o, mon_e.o, mon_e.cyc);
                    end
                end
            end
        end
    end

    initial begin
        int r, a, b;

        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_guess0", 32'(g0), 32'hFFFF);
        check("reset_count0", 32'(c0), 32'd0);
        check("reset_valid0", 32'(v0), 32'd0);
        check("reset_dup0", 32'(d0), 32'd0);
        check("reset_attempts0", 32'(a0), 32'd0);
        check("reset_guess1", 32'(g1), 32'hFFFF);
        rst_n = 1'b1;
        model_reset();
        last_push = model_obs();
        prev_obs = last_push;
        mon_en = 1'b1;
        repeat (5) @(posedge clk);

        // Four distinct digits, no handshake
        press(1, 10, 10);
        press(2, 10, 10);
        press(3, 10, 10);
        press(4, 10, 10);
        repeat (10) @(posedge clk);
        #1;
        check("t1_valid_held", 32'(v0), 32'd1);
        check("t1_guess", 32'(g0), 32'h1234);

        // Handshake, then new entry from SHOWN
        pulse_ready();
        #1;
        check("t2_attempts", 32'(a0), 32'd1);
        check("t2_guess_kept", 32'(g0), 32'h1234);
        check("t2_valid_low", 32'(v0), 32'd0);
        press(5, 10, 10);
        #1;
        check("t2_new_first", 32'(g0), 32'h5FFF);

        // Duplicate handling
        pulse_clear(1'b0);
        press(7, 10, 10);
        press(7, 10, 10);
        #1;
        check("t3_dup_rejected", 32'(g0), 32'h7FFF);
        check("t3_dup_allowed", 32'(g1), 32'h77FF);

        // Contact bounce on key 3, then a two-key chord
        pulse_clear(1'b0);
        @(posedge clk);
        #1;
        for (int i = 0; i < 10; i++) begin
            key[3] = ~key[3];
            repeat (2) @(posedge clk);
            #1;
        end
        key[3] = 1'b1;
        model_press(3, cyc + D + 4);
        repeat (15) @(posedge clk);
        #1;
        key = 10'd0;
        repeat (10) @(posedge clk);
        #1;
        key = 10'h024;
        repeat (12) @(posedge clk);
        #1;
        key = 10'd0;
        repeat (12) @(posedge clk);
        #1;
        check("t4_bounce_chord", 32'(g0), 32'h3FFF);

        // Clear beats a simultaneous handshake
        pulse_clear(1'b0);
        press(9, 10, 10);
        press(8, 10, 10);
        press(6, 10, 10);
        press(5, 10, 10);
        #1;
        check("t5_valid_before", 32'(v0), 32'd1);
        pulse_clear(1'b1);
        #1;
        check("t5_guess_cleared", 32'(g0), 32'hFFFF);
        check("t5_attempts_kept", 32'(a0), 32'd1);

        // Reset mid-debounce with the key still held
        @(posedge clk);
        #1;
        key = 10'h008;
        repeat (3) @(posedge clk);
        #2;
        model_reset();
        push_exp(-1);
        rst_n = 1'b0;
        #1;
        check("t6_async_guess", 32'(g0), 32'hFFFF);
        check("t6_async_attempts", 32'(a0), 32'd0);
        check("t6_async_count", 32'(c0), 32'd0);
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (20) @(posedge clk);
        #1;
        check("t6_held_no_event", 32'(g0), 32'hFFFF);
        key = 10'd0;
        repeat (10) @(posedge clk);
        press(3, 10, 10);
        #1;
        check("t6_repress", 32'(g0), 32'h3FFF);

        // Randomised mix of presses, handshakes, clears and chords
        for (int n = 0; n < 60; n++) begin
            r = $urandom_range(0, 9);
            if (r <= 5) begin
                press($urandom_range(0, 9), 10, 10);
            end else if (r <= 7) begin
                pulse_ready();
            end else if (r == 8) begin
                pulse_clear($urandom_range(0, 1) == 1);
            end else begin
                a = $urandom_range(0, 9);
                b = (a + $urandom_range(1, 9)) % 10;
                @(posedge clk);
                #1;
                key = (10'd1 << a) | (10'd1 << b);
                repeat (12) @(posedge clk);
                #1;
                key = 10'd0;
                repeat (12) @(posedge clk);
            end
        end

        // Attempts counter saturation
        pulse_clear(1'b0);
        for (int n = 0; n < 258; n++) begin
            press(1, 8, 8);
            press(2, 8, 8);
            press(3, 8, 8);
            press(4, 8, 8);
            pulse_ready();
        end
        #1;
        check("sat_attempts", 32'(a0), 32'd255);

        repeat (20) @(posedge clk);
        check("sb_drained", 32'(sb.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
